// File: rtl/mac_acc_ctrl.sv
// Accumulation controller for a pipelined adder: interleaves up to ADD_LAT+1
// partial sums through the adder, then folds them into one result.
module mac_acc_ctrl #(
  parameter int WIDTH   = 32,
  parameter int ADD_LAT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  output logic             o_add_valid,
  input  logic [WIDTH-1:0] i_add_val,
  input  logic             i_add_valid,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_sum_valid
);
  localparam int LW = $clog2(ADD_LAT + 2);

  typedef enum logic [1:0] {IDLE, ACCUM, REDUCE} state_t;

  state_t           state;
  logic [LW-1:0]    live;
  logic [WIDTH-1:0] hold;
  logic             hold_v;
  logic             acc, ret;

  assign o_ready = (state != REDUCE);
  assign acc     = i_valid & o_ready;
  // Nothing is live in IDLE, so any return there is stale and dropped.
  assign ret     = i_add_valid & (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      live        <= '0;
      hold        <= '0;
      hold_v      <= 1'b0;
      o_add_a     <= '0;
      o_add_b     <= '0;
      o_add_valid <= 1'b0;
      o_sum       <= '0;
      o_sum_valid <= 1'b0;
    end else begin
      o_add_valid <= 1'b0;
      o_sum_valid <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (ret || acc) begin
            o_add_valid <= 1'b1;
            o_add_a     <= ret ? i_add_val : i_data;
            o_add_b     <= (ret && acc) ? i_data : '0;
          end
          // A new partial only appears in a slot with no return, so live stays bounded.
          if (acc && !ret) live <= live + 1'b1;
          if (acc) state <= i_last ? REDUCE : ACCUM;
        end
        REDUCE: begin
          if (ret) begin
            if (hold_v) begin
              o_add_valid <= 1'b1;
              o_add_a     <= hold;
              o_add_b     <= i_add_val;
              hold_v      <= 1'b0;
              live        <= live - 1'b1;
            end else if (live > LW'(1)) begin
              hold   <= i_add_val;
              hold_v <= 1'b1;
            end else begin
              o_sum       <= i_add_val;
              o_sum_valid <= 1'b1;
              live        <= '0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_acc_ctrl.sv
// Bench for mac_acc_ctrl: models the 3-stage adder, scoreboards vector sums.
module tb_mac_acc_ctrl;
  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [W-1:0] i_data = '0;
  logic         i_valid = 1'b0;
  logic         i_last = 1'b0;
  logic         o_ready;
  logic [W-1:0] o_add_a, o_add_b, i_add_val, o_sum;
  logic         o_add_valid, i_add_valid, o_sum_valid;

  mac_acc_ctrl #(.WIDTH(W), .ADD_LAT(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .i_last(i_last), .o_ready(o_ready), .o_add_a(o_add_a), .o_add_b(o_add_b),
    .o_add_valid(o_add_valid), .i_add_val(i_add_val), .i_add_valid(i_add_valid),
    .o_sum(o_sum), .o_sum_valid(o_sum_valid)
  );

  always #5 i_clk = ~i_clk;

  // Reference adder: three registers, same reset as the block.
  logic [W-1:0] s0, s1, s2;
  logic         v0, v1, v2;
  always @(posedge i_clk) begin
    if (i_rst) begin
      s0 <= '0; s1 <= '0; s2 <= '0; v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
    end else begin
      s0 <= o_add_a + o_add_b; v0 <= o_add_valid;
      s1 <= s0; v1 <= v0;
      s2 <= s1; v2 <= v1;
    end
  end
  assign i_add_val   = s2;
  assign i_add_valid = v2;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  logic [W-1:0] exp_q[$];
  logic [W-1:0] run_sum = '0;
  int npulse = 0, pulse_cyc = -1, acc_cyc = -1;

  always @(negedge i_clk) begin
    if (o_sum_valid) begin
      pulse_cyc = cyc;
      npulse++;
      if (exp_q.size() == 0) chk("extra_pulse", 32'd1, 32'd0);
      else chk("sum", o_sum, exp_q.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic drive_beat(input logic [W-1:0] d, input logic l);
    int n = 0;
    i_valid = 1'b1; i_data = d; i_last = l;
    while (!o_ready && n < 100) begin @(negedge i_clk); n++; end
    if (!o_ready) chk("ready_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    if (l) begin
      exp_q.push_back(run_sum + d);
      run_sum = '0;
    end else begin
      run_sum = run_sum + d;
    end
    @(negedge i_clk);
    i_valid = 1'b0; i_last = 1'b0; i_data = '0;
  endtask

  task automatic idle_cyc();
    i_valid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n = 0;
    while (npulse < target && n < budget) begin @(negedge i_clk); n++; end
    chk("pulse_count", W'(npulse), W'(target));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_add_a"}, o_add_a, '0);
    chk({tag, "_add_b"}, o_add_b, '0);
    chk({tag, "_add_valid"}, {31'd0, o_add_valid}, 32'd0);
    chk({tag, "_sum"}, o_sum, '0);
    chk({tag, "_sum_valid"}, {31'd0, o_sum_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    int t0, np;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    chk_reset_vals("rst");
    i_rst = 1'b0;
    @(negedge i_clk);

    // Single beat: pulse exactly ADD_LAT+2 after acceptance, only once.
    drive_beat(32'd7, 1'b1);
    t0 = acc_cyc;
    wait_pulses(1, 20);
    chk("single_lat", W'(pulse_cyc - t0), 32'd5);
    repeat (8) idle_cyc();
    chk("single_once", W'(npulse), 32'd1);

    // Eight back-to-back beats.
    for (int i = 1; i <= 8; i++) drive_beat(W'(i), i == 8);
    wait_pulses(2, 60);
    repeat (3) idle_cyc();

    // Eight beats of 3 with bubbles at relative cycles 2, 5, 6.
    drive_beat(32'd3, 1'b0);
    t0 = acc_cyc;
    drive_beat(32'd3, 1'b0);
    idle_cyc();
    drive_beat(32'd3, 1'b0);
    drive_beat(32'd3, 1'b0);
    idle_cyc();
    chk("bubble_cyc", W'(cyc - t0), 32'd6);
    chk("bubble_recirc", {31'd0, o_add_valid}, 32'd1);
    idle_cyc();
    for (int i = 0; i < 4; i++) drive_beat(32'd3, i == 3);
    wait_pulses(3, 60);
    repeat (3) idle_cyc();

    // Modulo wrap.
    drive_beat(32'hFFFF_FFFF, 1'b0);
    drive_beat(32'h0000_0002, 1'b1);
    wait_pulses(4, 60);
    repeat (3) idle_cyc();

    // Reset while reducing a 10-beat vector.
    for (int i = 1; i <= 10; i++) drive_beat(W'(i), i == 10);
    idle_cyc();
    chk("in_reduce_ready", {31'd0, o_ready}, 32'd0);
    i_rst = 1'b1;
    @(negedge i_clk);
    exp_q.delete();
    chk_reset_vals("midrst");
    i_rst = 1'b0;
    np = npulse;
    repeat (15) idle_cyc();
    chk("abort_no_pulse", W'(npulse), W'(np));
    drive_beat(32'd5, 1'b1);
    wait_pulses(np + 1, 20);
    repeat (3) idle_cyc();

    // Back-to-back vectors, second one accepted in the pulse cycle.
    np = npulse;
    for (int i = 0; i < 3; i++) drive_beat(32'd1, i == 2);
    drive_beat(32'd10, 1'b0);
    chk("b2b_start", W'(acc_cyc), W'(pulse_cyc));
    drive_beat(32'd20, 1'b1);
    wait_pulses(np + 2, 60);
    repeat (10) idle_cyc();
    chk("queue_empty", W'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
